// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared FSM encoding, command field positions and default depths
package spi_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ARM   = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam int CMD_W         = 11;
    localparam int CAP_BIT       = 10;
    localparam int DC_BIT        = 9;
    localparam int END_BIT       = 8;
    localparam int BYTE_MSB      = 7;
    localparam int DEF_CMD_DEPTH = 4;
    localparam int DEF_RD_DEPTH  = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
// A push into a full FIFO is ignored even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - queued SPI byte-command sequencer with read-data capture FIFO
// Issues one spi_ctrl transfer at a time from the command FIFO and captures flagged MISO bytes.
module spi_cmd_sequencer
    import spi_seq_pkg::*;
#(
    parameter int CMD_DEPTH = DEF_CMD_DEPTH,
    parameter int RD_DEPTH  = DEF_RD_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    input  logic [CMD_W-1:0]               cmd_data,
    output logic                           cmd_ready,
    output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count,
    output logic                           overflow,
    input  logic                           clr_overflow,
    input  logic                           rd_pop,
    output logic [7:0]                     rd_data,
    output logic                           rd_valid,
    output logic                           idle,
    output logic                           spi_start,
    output logic [7:0]                     spi_byte,
    output logic                           spi_dc,
    output logic                           spi_end_txn,
    input  logic                           spi_busy,
    input  logic [7:0]                     spi_rdata
);

    localparam int RCW = $clog2(RD_DEPTH+1);

    state_t           state;
    state_t           state_next;
    logic [CMD_W-1:0] cmd_head;
    logic             cmd_empty;
    logic             cmd_full;
    logic             cmd_pop;
    logic [7:0]       rd_head;
    logic             rd_empty;
    logic             rd_full;
    logic [RCW-1:0]   rd_cnt;
    logic             rd_push;
    logic             cap_q;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (cmd_data),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_push),
        .wdata (spi_rdata),
        .pop   (rd_pop),
        .rdata (rd_head),
        .full  (rd_full),
        .empty (rd_empty),
        .count (rd_cnt)
    );

    assign cmd_ready = !cmd_full;
    assign rd_valid  = (rd_cnt != '0);
    assign rd_data   = rd_empty ? 8'hFF : rd_head;
    assign idle      = cmd_empty && (state == ST_IDLE);

    // A capture is held back while the read FIFO is full so it can never overflow.
    always_comb begin
        state_next = state;
        cmd_pop    = 1'b0;
        rd_push    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cmd_empty && (!cmd_head[CAP_BIT] || !rd_full)) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmd_pop    = 1'b1;
                state_next = ST_ARM;
            end
            ST_ARM: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!spi_busy) begin
                    rd_push    = cap_q;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            spi_start   <= 1'b0;
            spi_byte    <= 8'h00;
            spi_dc      <= 1'b0;
            spi_end_txn <= 1'b0;
            cap_q       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state     <= state_next;
            spi_start <= (state_next == ST_ISSUE);
            if (state == ST_IDLE && state_next == ST_ISSUE) begin
                spi_byte    <= cmd_head[BYTE_MSB:0];
                spi_dc      <= cmd_head[DC_BIT];
                spi_end_txn <= cmd_head[END_BIT];
                cap_q       <= cmd_head[CAP_BIT];
            end
            if (cmd_valid && cmd_full) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - scoreboard bench for spi_cmd_sequencer with a behavioural spi_ctrl
module tb_spi_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [10:0] cmd_data = '0;
    logic        cmd_ready;
    logic [2:0]  cmd_count;
    logic        overflow;
    logic        clr_overflow = 1'b0;
    logic        rd_pop = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        idle;
    logic        spi_start;
    logic [7:0]  spi_byte;
    logic        spi_dc;
    logic        spi_end_txn;
    logic        spi_busy;
    logic [7:0]  spi_rdata;

    int errors = 0;
    int checks = 0;
    int n_starts = 0;

    logic [10:0] start_q[$];
    logic [7:0]  rd_q[$];

    always #5 clk = ~clk;

    spi_cmd_sequencer #(.CMD_DEPTH(4), .RD_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .cmd_count    (cmd_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .rd_pop       (rd_pop),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .idle         (idle),
        .spi_start    (spi_start),
        .spi_byte     (spi_byte),
        .spi_dc       (spi_dc),
        .spi_end_txn  (spi_end_txn),
        .spi_busy     (spi_busy),
        .spi_rdata    (spi_rdata)
    );

    // spi_ctrl model: busy for 8 cycles after start, returns rdata_base (optionally + transfer index)
    logic       model_busy = 1'b0;
    int         model_cnt = 0;
    logic       force_busy = 1'b0;
    logic [7:0] model_rdata = 8'h00;
    logic [7:0] rdata_base = 8'h3C;
    logic       rdata_inc = 1'b0;
    logic [7:0] start_idx = 8'h00;
    logic [7:0] next_rdata;

    assign next_rdata = rdata_inc ? rdata_base + start_idx : rdata_base;
    assign spi_busy   = model_busy | force_busy;
    assign spi_rdata  = model_rdata;

    always @(posedge clk) begin
        if (rst) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (spi_start) begin
            model_busy  <= 1'b1;
            model_cnt   <= 7;
            model_rdata <= next_rdata;
            start_idx   <= start_idx + 8'd1;
        end else if (model_busy) begin
            if (model_cnt == 0) model_busy <= 1'b0;
            else                model_cnt  <= model_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        if (spi_start === 1'b1) begin
            n_starts++;
            check("start_expected", 32'(start_q.size() != 0), 32'd1);
            if (start_q.size() != 0) begin
                e = start_q.pop_front();
                check("start_fields", 32'({spi_dc, spi_end_txn, spi_byte}),
                      32'({e[9], e[8], e[7:0]}));
                if (e[10]) rd_q.push_back(next_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [10:0] d, input bit expect_ok);
        cmd_valid = 1'b1;
        cmd_data  = d;
        if (expect_ok) start_q.push_back(d);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (idle !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(idle), 32'd1);
    endtask

    task automatic rd_pop_check(input string tag);
        logic [7:0] e = 8'hFF;
        if (rd_q.size() != 0) e = rd_q.pop_front();
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(e));
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
    endtask

    initial begin
        int snap;
        int n;

        // reset values
        repeat (2) tick();
        check("rst_start", 32'(spi_start), 32'd0);
        check("rst_count", 32'(cmd_count), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'hFF);
        check("rst_byte", 32'({spi_dc, spi_end_txn, spi_byte}), 32'd0);
        rst = 1'b0;
        tick();

        // 1: three back-to-back commands, latency, single capture
        push(11'h0A5, 1'b1);
        check("t1_no_start_yet", 32'(spi_start), 32'd0);
        push(11'h35A, 1'b1);
        check("t1_latency", 32'(spi_start), 32'd1);
        push(11'h4FF, 1'b1);
        wait_idle("t1_idle");
        check("t1_starts", 32'(n_starts), 32'd3);
        rd_pop_check("t1_rd");
        check("t1_rd_empty", 32'(rd_valid), 32'd0);

        // 2: fill while stalled, overflow, set-wins, clear
        force_busy = 1'b1;
        push(11'h011, 1'b1);
        repeat (4) tick();
        for (int i = 0; i < 4; i++) push(11'h020 + 11'(i), 1'b1);
        check("t2_count_full", 32'(cmd_count), 32'd4);
        check("t2_ready_low", 32'(cmd_ready), 32'd0);
        push(11'h0EE, 1'b0);
        check("t2_overflow_set", 32'(overflow), 32'd1);
        check("t2_count_held", 32'(cmd_count), 32'd4);
        cmd_valid = 1'b1;
        cmd_data = 11'h0EF;
        clr_overflow = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("t2_set_wins", 32'(overflow), 32'd1);
        tick();
        clr_overflow = 1'b0;
        check("t2_overflow_clr", 32'(overflow), 32'd0);
        force_busy = 1'b0;
        wait_idle("t2_idle");

        // 3: read FIFO full blocks a capture until a pop
        rdata_base = 8'h60;
        rdata_inc = 1'b1;
        for (int i = 0; i < 4; i++) push(11'h4A0 + 11'(i), 1'b1);
        wait_idle("t3_fill_idle");
        push(11'h4B0, 1'b1);
        snap = n_starts;
        repeat (10) tick();
        check("t3_gate_hold", 32'(n_starts), 32'(snap));
        check("t3_gate_count", 32'(cmd_count), 32'd1);
        check("t3_gate_not_idle", 32'(idle), 32'd0);
        rd_pop_check("t3_pop");
        check("t3_start_not_yet", 32'(spi_start), 32'd0);
        tick();
        check("t3_start_after_pop", 32'(spi_start), 32'd1);
        wait_idle("t3_idle");
        for (int i = 0; i < 4; i++) rd_pop_check("t3_drain");
        check("t3_rd_empty", 32'(rd_valid), 32'd0);

        // 4: reset during WAIT abandons the capture and clears everything
        push(11'h4AA, 1'b1);
        wait_idle("t4_pre_idle");
        force_busy = 1'b1;
        push(11'h433, 1'b1);
        repeat (4) tick();
        for (int i = 0; i < 5; i++) push(11'h050 + 11'(i), 1'b0);
        check("t4_pre_overflow", 32'(overflow), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        force_busy = 1'b0;
        start_q.delete();
        rd_q.delete();
        check("t4_start", 32'(spi_start), 32'd0);
        check("t4_count", 32'(cmd_count), 32'd0);
        check("t4_rd_valid", 32'(rd_valid), 32'd0);
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_idle", 32'(idle), 32'd1);
        snap = n_starts;
        repeat (12) tick();
        check("t4_no_capture", 32'(rd_valid), 32'd0);
        check("t4_no_starts", 32'(n_starts), 32'(snap));

        // 5: cmd push + FSM pop in one cycle; rd push + pop in one cycle
        rdata_base = 8'h50;
        force_busy = 1'b1;
        push(11'h001, 1'b1);
        repeat (4) tick();
        for (int i = 0; i < 3; i++) push(11'h410 + 11'(i), 1'b1);
        check("t5_count3", 32'(cmd_count), 32'd3);
        force_busy = 1'b0;
        n = 0;
        while (spi_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t5_issue_seen", 32'(spi_start), 32'd1);
        push(11'h413, 1'b1);
        check("t5_count_stays", 32'(cmd_count), 32'd3);
        wait_idle("t5_idle");
        rd_pop_check("t5_pop_a");
        rd_pop_check("t5_pop_b");
        force_busy = 1'b1;
        push(11'h414, 1'b1);
        repeat (14) tick();
        check("t5_both_head", 32'(rd_data), 32'(rd_q.pop_front()));
        rd_pop = 1'b1;
        force_busy = 1'b0;
        tick();
        rd_pop = 1'b0;
        check("t5_both_idle", 32'(idle), 32'd1);
        rd_pop_check("t5_order_a");
        rd_pop_check("t5_order_b");
        check("t5_rd_empty", 32'(rd_valid), 32'd0);

        // 6: pop on empty read FIFO is ignored
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        check("t6_rd_valid", 32'(rd_valid), 32'd0);
        check("t6_rd_data", 32'(rd_data), 32'hFF);
        check("t6_idle", 32'(idle), 32'd1);
        check("t6_count", 32'(cmd_count), 32'd0);
        push(11'h4C0, 1'b1);
        wait_idle("t6_idle_after");
        rd_pop_check("t6_after");
        check("t6_rd_empty", 32'(rd_valid), 32'd0);

        check("end_start_q", 32'(start_q.size()), 32'd0);
        check("end_rd_q", 32'(rd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
